mul_share_arbiter: RTL and testbench
====================================

Name: mul_share_arbiter

Overview:
Shares one sequential signed multiplier (start/done handshake, 5-bit two's-complement operands) between N_REQ requesters. Performs round-robin arbitration and latches the winner's operands. Sequences the multiplier through start and completion, then returns the product with a per-requester response pulse. A watchdog timeout recovers from a multiplier that never signals done.

Parameters:
N_REQ, 4, number of requesters (2..8)
OP_W, 5, operand width, signed two's complement
RES_W, 10, product width, always 2*OP_W
TIMEOUT, 15, maximum cycles spent in WAIT before the error response is issued (>=1)

Ports:
clk  input  1  clock, rising edge
n_rst  input  1  asynchronous active-low reset
req  input  N_REQ  per-requester request level
req_m  input  N_REQ*OP_W  multiplicands; requester i uses bits [i*OP_W +: OP_W]
req_q  input  N_REQ*OP_W  multipliers, same packing as req_m
gnt  output  N_REQ  one-hot accept pulse (combinational)
rsp_valid  output  N_REQ  one-hot response pulse, registered
rsp_data  output  RES_W  signed product, valid while any rsp_valid bit is high
rsp_err  output  1  high with rsp_valid when the transaction timed out
mul_start  output  1  one-cycle start pulse to the multiplier, registered
mul_m  output  OP_W  latched multiplicand, held stable from ISSUE to end of WAIT
mul_q  output  OP_W  latched multiplier, same hold rule as mul_m
mul_done  input  1  multiplier completion pulse
mul_result  input  RES_W  multiplier product, sampled when mul_done is high
busy  output  1  high in every state except IDLE, registered

Behaviour:
- Reset (async, n_rst=0): state=IDLE; rr_ptr=0; all outputs 0, including mul_m, mul_q, rsp_data and the timeout counter.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, request present: if any req bit is high, winner = first set req at or above rr_ptr, searching with wrap-around modulo N_REQ.
  - gnt[winner]=1 in that same cycle.
  - At the clock edge: operands are latched into mul_m/mul_q, the winner index is stored, and state goes to ISSUE.
- IDLE, no request: gnt=0 and state stays IDLE.
- gnt is zero in every state other than IDLE.
- Requester handshake: hold req and operands stable until gnt is seen; deassert or present the next request afterwards.
  - A request dropped before grant is simply not served.
  - A request still high after its own response is re-arbitrated normally.
- ISSUE: mul_start=1 for exactly this one cycle. Counter is cleared. Next state WAIT.
- WAIT: counter increments each cycle.
  - mul_done=1: capture mul_result into rsp_data, set rsp_err=0, next state RESP.
  - Otherwise, counter reaches TIMEOUT: rsp_data=0, rsp_err=1, next state RESP.
  - mul_done and timeout in the same cycle: mul_done wins, so the response is the normal product.
- mul_done is ignored in IDLE, ISSUE and RESP. It is never latched for later use.
- RESP: rsp_valid[stored winner]=1 for exactly one cycle. rr_ptr becomes (winner+1) mod N_REQ. Next state IDLE.
- rsp_valid, rsp_data and rsp_err are 0 outside RESP.
- Latency: gnt in cycle t, mul_start in t+1. If mul_done arrives in cycle t+1+k (k>=1), rsp_valid is in t+2+k. The earliest next gnt is t+3+k.
- Arithmetic: no sign extension or truncation in this block. Operands pass through unmodified and the product is returned at full RES_W.
- Only one transaction is outstanding at a time; there is no queueing.
- Reset mid-operation: transaction abandoned and no response pulse. The multiplier is expected to be reset by the same n_rst.

Test Plan:
- Single request: req[0]=1, M=5, Q=3 -> gnt[0] same cycle, mul_start next cycle. With a model multiplier giving done after 4 cycles: rsp_valid[0] with rsp_data=10'd15, rsp_err=0, busy low afterwards.
- Signed operands: req[2]=1, M=-3 (5'b11101), Q=7 -> rsp_valid[2], rsp_data=10'h3EB (-21). mul_m/mul_q remain 5'b11101/5'b00111 throughout WAIT.
- Round robin: all four req held high for 8 transactions from reset -> grant order 0,1,2,3,0,1,2,3, exactly one gnt pulse per transaction.
- Pointer rotation: after serving requester 2, req={3,0} high -> requester 3 granted before 0.
- Timeout: mul_done tied low, TIMEOUT=15 -> rsp_valid[winner] with rsp_err=1 and rsp_data=0, then IDLE. With mul_done on the expiry cycle instead -> rsp_err=0 and the correct product.
- Reset mid-WAIT: pulse n_rst low -> immediately busy=0 and all outputs 0, no rsp_valid. After release, a new req[1] is granted first (rr_ptr=0 scan from index 0 finds 1).

Source files
------------

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter that time-shares one sequential signed multiplier among N_REQ
// requesters, with a watchdog that turns a missing mul_done into an error response.
module mul_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int OP_W    = 5,
    parameter int RES_W   = 2 * OP_W,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*OP_W-1:0] req_m,
    input  logic [N_REQ*OP_W-1:0] req_q,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [RES_W-1:0]      rsp_data,
    output logic                  rsp_err,
    output logic                  mul_start,
    output logic [OP_W-1:0]       mul_m,
    output logic [OP_W-1:0]       mul_q,
    input  logic                  mul_done,
    input  logic [RES_W-1:0]      mul_result,
    output logic                  busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OP_W-1:0]  mul_m_q, mul_m_d;
    logic [OP_W-1:0]  mul_q_q, mul_q_d;
    logic             mul_start_q, mul_start_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [RES_W-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             busy_q, busy_d;

    logic             req_any;
    logic [IDX_W-1:0] win_idx;
    int               scan;

    // Scan starts at rr_ptr and wraps, so the last-served requester goes to the back.
    always_comb begin
        req_any = 1'b0;
        win_idx = '0;
        scan    = 0;
        for (int i = 0; i < N_REQ; i++) begin
            scan = int'(rr_ptr_q) + i;
            if (scan >= N_REQ) scan = scan - N_REQ;
            if (!req_any && req[scan]) begin
                req_any = 1'b1;
                win_idx = IDX_W'(scan);
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (state_q == IDLE && req_any) gnt[win_idx] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
        mul_m_d     = mul_m_q;
        mul_q_d     = mul_q_q;
        rsp_valid_d = '0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    win_d   = win_idx;
                    mul_m_d = req_m[int'(win_idx)*OP_W +: OP_W];
                    mul_q_d = req_q[int'(win_idx)*OP_W +: OP_W];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A done on the expiry cycle still wins over the timeout.
                if (mul_done) begin
                    rsp_valid_d[win_q] = 1'b1;
                    rsp_data_d         = mul_result;
                    state_d            = RESP;
                end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                    rsp_valid_d[win_q] = 1'b1;
                    rsp_err_d          = 1'b1;
                    state_d            = RESP;
                end
            end
            RESP: begin
                if (win_q == IDX_W'(N_REQ - 1)) rr_ptr_d = '0;
                else                            rr_ptr_d = win_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        mul_start_d = (state_d == ISSUE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            cnt_q       <= '0;
            mul_m_q     <= '0;
            mul_q_q     <= '0;
            mul_start_q <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            mul_m_q     <= mul_m_d;
            mul_q_q     <= mul_q_d;
            mul_start_q <= mul_start_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign mul_start = mul_start_q;
    assign mul_m     = mul_m_q;
    assign mul_q     = mul_q_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Randomized bench for mul_share_arbiter: the bench plays the requesters and the
// multiplier, and predicts winners/products from a round-robin pointer and integer math.
module tb_mul_share_arbiter;
    localparam int N_REQ   = 4;
    localparam int OP_W    = 5;
    localparam int RES_W   = 10;
    localparam int TIMEOUT = 15;
    localparam int VW      = N_REQ * OP_W;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic [N_REQ-1:0] req = '0;
    logic [VW-1:0]    req_m = '0;
    logic [VW-1:0]    req_q = '0;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] rsp_valid;
    logic [RES_W-1:0] rsp_data;
    logic             rsp_err;
    logic             mul_start;
    logic [OP_W-1:0]  mul_m;
    logic [OP_W-1:0]  mul_q;
    logic             mul_done = 1'b0;
    logic [RES_W-1:0] mul_result = '0;
    logic             busy;

    int n_chk = 0;
    int n_pass = 0;
    int ptr_m = 0;

    always #5 clk = ~clk;

    mul_share_arbiter #(.N_REQ(N_REQ), .OP_W(OP_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .n_rst(n_rst), .req(req), .req_m(req_m), .req_q(req_q), .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .mul_start(mul_start),
        .mul_m(mul_m), .mul_q(mul_q), .mul_done(mul_done), .mul_result(mul_result), .busy(busy)
    );

    function automatic int pick(input logic [N_REQ-1:0] r, input int ptr);
        for (int i = 0; i < N_REQ; i++)
            if (r[(ptr + i) % N_REQ]) return (ptr + i) % N_REQ;
        return 0;
    endfunction

    function automatic logic [RES_W-1:0] prod(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
        int x, y, p;
        x = int'($signed(a));
        y = int'($signed(b));
        p = x * y;
        return p[RES_W-1:0];
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input int w);
        logic [N_REQ-1:0] v;
        v = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    // k = cycle offset of mul_done after mul_start (0 = never); spur pulses done during ISSUE.
    task automatic run_txn(input logic [N_REQ-1:0] r, input logic [VW-1:0] m, input logic [VW-1:0] q,
                           input int k, input bit keep, input bit spur,
                           output logic [N_REQ-1:0] g, output logic st,
                           output logic [OP_W-1:0] mm, output logic [OP_W-1:0] mq,
                           output bit stable, output bit leak,
                           output logic [N_REQ-1:0] rv, output logic [RES_W-1:0] rd,
                           output logic re, output int rj, output logic busy_after);
        int c;
        req = r; req_m = m; req_q = q;
        #1;
        c = 0; stable = 1; leak = 0; rv = '0; rd = '0; re = 1'b0; rj = -1;
        st = 1'b0; mm = '0; mq = '0; busy_after = 1'b1;
        while (gnt == '0 && c < 20) begin
            @(negedge clk); #1; c++;
        end
        g = gnt;
        if (gnt == '0) return;
        @(negedge clk);
        if (!keep) req = '0;
        #1;
        st = mul_start; mm = mul_m; mq = mul_q;
        if (gnt != '0 || rsp_valid != '0 || busy !== 1'b1) leak = 1;
        mul_done = spur; mul_result = RES_W'($urandom);
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                rv = rsp_valid; rd = rsp_data; re = rsp_err; rj = j;
                break;
            end
            if (mul_m !== mm || mul_q !== mq || busy !== 1'b1) stable = 0;
            if (mul_start !== 1'b0 || gnt != '0 || rsp_data != '0 || rsp_err !== 1'b0) leak = 1;
            mul_done = (j == k);
            mul_result = (j == k) ? prod(mul_m, mul_q) : RES_W'($urandom);
        end
        mul_done = 1'b0;
        if (rj < 0) return;
        @(negedge clk);
        busy_after = busy;
        if (rsp_valid != '0 || rsp_data != '0 || rsp_err !== 1'b0) leak = 1;
    endtask

    logic [N_REQ-1:0] g, rv, eg;
    logic             st, re, ba;
    logic [OP_W-1:0]  mm, mq;
    logic [RES_W-1:0] rd, ed;
    logic [VW-1:0]    vm, vq;
    bit               stb, lk;
    int               rj, w;

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_chk++; if ({gnt, rsp_valid, rsp_err, mul_start} !== '0) $display("FAIL reset_ctl got=%b exp=0", {gnt, rsp_valid, rsp_err, mul_start}); else n_pass++;
        n_chk++; if ({mul_m, mul_q, rsp_data} !== '0) $display("FAIL reset_data got=%h exp=0", {mul_m, mul_q, rsp_data}); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_rst = 1'b1;
        @(negedge clk);
        ptr_m = 0;
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 8; i++) begin
            vm = VW'($urandom); vq = VW'($urandom);
            w = pick(4'hF, ptr_m);
            run_txn(4'hF, vm, vq, $urandom_range(1, 5), i < 7, 1'b0, g, st, mm, mq, stb, lk, rv, rd, re, rj, ba);
            n_chk++; if (g !== onehot(i % N_REQ) || g !== onehot(w)) $display("FAIL rr_gnt txn=%0d got=%b exp=%b", i, g, onehot(i % N_REQ)); else n_pass++;
            n_chk++; if (rv !== onehot(w) || rd !== prod(vm[w*OP_W +: OP_W], vq[w*OP_W +: OP_W]) || lk)
                $display("FAIL rr_rsp txn=%0d got=%b/%h leak=%0d exp=%b/%h", i, rv, rd, lk, onehot(w), prod(vm[w*OP_W +: OP_W], vq[w*OP_W +: OP_W]));
            else n_pass++;
            ptr_m = (w + 1) % N_REQ;
        end
    endtask

    task automatic test_single();
        vm = VW'($urandom); vq = VW'($urandom);
        vm[OP_W-1:0] = 5'd5; vq[OP_W-1:0] = 5'd3;
        run_txn(4'b0001, vm, vq, 4, 1'b0, 1'b0, g, st, mm, mq, stb, lk, rv, rd, re, rj, ba);
        n_chk++; if (g !== 4'b0001 || st !== 1'b1) $display("FAIL single_gnt got=%b start=%b exp=0001/1", g, st); else n_pass++;
        n_chk++; if (rv !== 4'b0001 || rd !== 10'd15 || re !== 1'b0) $display("FAIL single_rsp got=%b/%h/%b exp=0001/00f/0", rv, rd, re); else n_pass++;
        n_chk++; if (rj !== 5) $display("FAIL single_latency got=%0d exp=5", rj); else n_pass++;
        n_chk++; if (ba !== 1'b0 || lk) $display("FAIL single_idle busy=%b leak=%0d exp=0/0", ba, lk); else n_pass++;
        ptr_m = 1;
    endtask

    task automatic test_signed();
        vm = VW'($urandom); vq = VW'($urandom);
        vm[2*OP_W +: OP_W] = 5'b11101; vq[2*OP_W +: OP_W] = 5'b00111;
        run_txn(4'b0100, vm, vq, 6, 1'b0, 1'b0, g, st, mm, mq, stb, lk, rv, rd, re, rj, ba);
        n_chk++; if (rv !== 4'b0100 || rd !== 10'h3EB || re !== 1'b0) $display("FAIL signed_rsp got=%b/%h/%b exp=0100/3eb/0", rv, rd, re); else n_pass++;
        n_chk++; if (mm !== 5'b11101 || mq !== 5'b00111 || !stb) $display("FAIL signed_ops got=%b/%b stable=%0d exp=11101/00111/1", mm, mq, stb); else n_pass++;
        ptr_m = 3;
    endtask

    task automatic test_rotation();
        vm = VW'($urandom); vq = VW'($urandom);
        run_txn(4'b1001, vm, vq, 2, 1'b0, 1'b0, g, st, mm, mq, stb, lk, rv, rd, re, rj, ba);
        n_chk++; if (g !== 4'b1000 || g !== onehot(pick(4'b1001, ptr_m))) $display("FAIL rot_first got=%b exp=1000", g); else n_pass++;
        ptr_m = 0;
        run_txn(4'b1001, vm, vq, 2, 1'b0, 1'b0, g, st, mm, mq, stb, lk, rv, rd, re, rj, ba);
        n_chk++; if (g !== 4'b0001) $display("FAIL rot_second got=%b exp=0001", g); else n_pass++;
        ptr_m = 1;
    endtask

    task automatic test_timeout();
        vm = VW'($urandom); vq = VW'($urandom);
        w = pick(4'b0110, ptr_m);
        run_txn(4'b0110, vm, vq, 0, 1'b0, 1'b0, g, st, mm, mq, stb, lk, rv, rd, re, rj, ba);
        n_chk++; if (rv !== onehot(w) || re !== 1'b1 || rd !== '0) $display("FAIL timeout_rsp got=%b/%b/%h exp=%b/1/000", rv, re, rd, onehot(w)); else n_pass++;
        n_chk++; if (rj !== TIMEOUT + 1 || ba !== 1'b0) $display("FAIL timeout_len got=%0d busy=%b exp=%0d/0", rj, ba, TIMEOUT + 1); else n_pass++;
        ptr_m = (w + 1) % N_REQ;
        w = pick(4'b1111, ptr_m);
        run_txn(4'b1111, vm, vq, TIMEOUT, 1'b0, 1'b0, g, st, mm, mq, stb, lk, rv, rd, re, rj, ba);
        ed = prod(vm[w*OP_W +: OP_W], vq[w*OP_W +: OP_W]);
        n_chk++; if (rv !== onehot(w) || re !== 1'b0 || rd !== ed || rj !== TIMEOUT + 1)
            $display("FAIL expiry_done got=%b/%b/%h at %0d exp=%b/0/%h at %0d", rv, re, rd, rj, onehot(w), ed, TIMEOUT + 1);
        else n_pass++;
        ptr_m = (w + 1) % N_REQ;
    endtask

    task automatic test_random();
        logic [N_REQ-1:0] r;
        int k;
        for (int i = 0; i < 12; i++) begin
            r = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            vm = VW'($urandom); vq = VW'($urandom);
            k = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
            w = pick(r, ptr_m);
            eg = onehot(w);
            ed = (k == 0) ? '0 : prod(vm[w*OP_W +: OP_W], vq[w*OP_W +: OP_W]);
            run_txn(r, vm, vq, k, 1'b0, 1'($urandom_range(0, 1)), g, st, mm, mq, stb, lk, rv, rd, re, rj, ba);
            n_chk++; if (g !== eg || rv !== eg || st !== 1'b1) $display("FAIL rand_gnt txn=%0d req=%b got=%b/%b exp=%b", i, r, g, rv, eg); else n_pass++;
            n_chk++; if (rd !== ed || re !== (k == 0) || rj !== ((k == 0) ? TIMEOUT + 1 : k + 1) || lk || !stb)
                $display("FAIL rand_rsp txn=%0d got=%h/%b@%0d exp=%h/%b@%0d", i, rd, re, rj, ed, k == 0, (k == 0) ? TIMEOUT + 1 : k + 1);
            else n_pass++;
            ptr_m = (w + 1) % N_REQ;
        end
    endtask

    task automatic test_reset_mid_wait();
        int c, seen;
        req = 4'b0100; req_m = '0; req_q = '0;
        req_m[2*OP_W +: OP_W] = 5'b01011; req_q[2*OP_W +: OP_W] = 5'b00110;
        #1;
        c = 0;
        while (gnt == '0 && c < 20) begin @(negedge clk); #1; c++; end
        @(negedge clk); req = '0;
        repeat (2) @(negedge clk);
        n_rst = 1'b0;
        #1;
        n_chk++; if (busy !== 1'b0 || mul_start !== 1'b0 || rsp_valid !== '0) $display("FAIL midrst_ctl busy=%b start=%b rv=%b exp=0", busy, mul_start, rsp_valid); else n_pass++;
        n_chk++; if ({mul_m, mul_q, rsp_data, rsp_err} !== '0) $display("FAIL midrst_data got=%h exp=0", {mul_m, mul_q, rsp_data, rsp_err}); else n_pass++;
        @(negedge clk);
        n_rst = 1'b1; mul_done = 1'b1; mul_result = 10'h155;
        seen = 0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            mul_done = 1'b0;
            if (rsp_valid != '0 || busy !== 1'b0) seen++;
        end
        n_chk++; if (seen != 0) $display("FAIL midrst_quiet got=%0d exp=0", seen); else n_pass++;
        ptr_m = 0;
        vm = VW'($urandom); vq = VW'($urandom);
        run_txn(4'b1010, vm, vq, 2, 1'b0, 1'b0, g, st, mm, mq, stb, lk, rv, rd, re, rj, ba);
        n_chk++; if (g !== 4'b0010 || rv !== onehot(pick(4'b1010, ptr_m))) $display("FAIL midrst_regrant got=%b/%b exp=0010", g, rv); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_signed();
        test_rotation();
        test_timeout();
        test_random();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish (%0d/%0d)", n_pass, n_chk);
        $fatal(1);
    end
endmodule
